muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative multiply/divide sequencer owning the HI/LO registers of the MIPS pipeline.
//  Accepts MULT/MULTU/DIV/DIVU from the execute stage and runs a multi-cycle shift-add or restoring-divide loop.
//  Raises muldivstall so the hazard unit holds F/D and flushes E while an access must wait on busy HI/LO.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO width; iteration count
// PORTS
//  clk          in   1      pipeline clock
//  reset        in   1      synchronous, active-high reset
//  start        in   1      E-stage muldiv instruction valid, already qualified by !flushe
//  op           in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  srca         in   WIDTH  rs operand / dividend / multiplicand; MTHI/MTLO data
//  srcb         in   WIDTH  rt operand / divisor / multiplier
//  hiread       in   1      E-stage MFHI
//  loread       in   1      E-stage MFLO
//  hiwrite      in   1      E-stage MTHI
//  lowrite      in   1      E-stage MTLO
//  hi           out  WIDTH  HI register (remainder / product upper)
//  lo           out  WIDTH  LO register (quotient / product lower)
//  busy         out  1      loop in progress (state != IDLE)
//  done         out  1      1-cycle pulse: HI/LO just updated by an operation
//  muldivstall  out  1      busy & (start|hiread|loread|hiwrite|lowrite); ORed into stallf/stalld/flushe
// BEHAVIOUR
//  - Reset: state IDLE, hi=0, lo=0, busy=0, done=0, count=0; reset mid-op aborts the op and discards the result.
//  - States: IDLE -> MUL|DIV on start; MUL|DIV -> FIX when count hits WIDTH-1; FIX -> IDLE unconditionally.
//  - Accept: start is sampled only in IDLE, at edge k. busy=1 for cycles k+1..k+WIDTH+1 (WIDTH loop cycles, 1 FIX cycle).
//    HI/LO are written at the edge ending FIX. done=1 and the new HI/LO are visible in cycle k+WIDTH+2.
//  - Start while busy: ignored and muldivstall=1. The pipeline holds E, so start is re-presented and accepted
//    in the first IDLE cycle.
//  - Signed ops: the loop runs on |srca|, |srcb|; signs are latched at accept.
//    FIX negates the product if the signs differ.
//    DIV: quotient negated if the signs differ; remainder takes the dividend sign.
//  - MUL loop: {acc,mplr} shifts right one bit per cycle; acc += mcand when mplr[0].
//    Adder is WIDTH+1 bits; the carry enters acc MSB.
//  - DIV loop: restoring. {rem,quo} shifts left; rem-divisor is computed at WIDTH+1 bits;
//    if non-negative, rem updates and quo LSB=1.
//  - Divide by zero (srcb==0 at accept): runs the full latency; lo={WIDTH{1}}, hi=srca; sign fixup skipped.
//  - Signed overflow (-2^(W-1) / -1): lo=0x80000000 (W=32), hi=0. No trap.
//  - MTHI/MTLO in IDLE: hi/lo<=srca next edge. Busy: stalled via muldivstall.
//    Same-cycle start+hiwrite is impossible (one E instruction).
//  - MFHI/MFLO: hi/lo are read combinationally from the regs; the stall guarantees no stale read.
//    Data is available the cycle done=1.
// CONFIGURATION
//  - MULDIV_EARLY_OUT_EN defined: MUL exits to FIX after any loop cycle in which the remaining
//    (post-shift) multiplier is 0. The result is still aligned: acc/mplr are shifted by the remaining
//    count in FIX. Minimum 1 MUL cycle, so srcb==0 gives busy for 2 cycles. DIV is unaffected.
//  - Undefined: MUL always takes WIDTH loop cycles. Latency is fixed and identical for all ops.
// STRUCTURE
//  - Package mips_muldiv_pkg: op encodings (OP_MULT..OP_DIVU), state enum (IDLE, MUL, DIV, FIX),
//    counter width $clog2(WIDTH).
//  - Sub-module muldiv_shift_core: acc/quotient shift registers plus the WIDTH+1 add/sub.
//    Controlled by mode/step/load; the FSM, counter, sign fixup, HI/LO regs and stall stay in the top.
// TESTING
//  - MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done at accept+34 (macro off).
//  - MULT -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  - MFLO one cycle after accept -> muldivstall=1 through FIX; the read returns the new lo in the done cycle.
//    A second start while busy is accepted only after IDLE.
//  - reset asserted mid-DIV -> next cycle busy=0, hi=lo=0; a following MTLO 0x1234 -> lo=0x1234.
//  - MULDIV_EARLY_OUT_EN: MULTU 9*3 -> busy 3 cycles, hi=0, lo=27; MULTU 9*0 -> busy 2 cycles, lo=0.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op codes, FSM states,
// datapath modes and the iteration-counter width helper.
package mips_muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

    // Counter holds 0..width-1, so clog2(width) bits suffice.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/muldiv_shift_core.sv
// Shift/add-subtract datapath for the multiply/divide loop: accumulator/remainder,
// multiplier/quotient shift register, and the WIDTH+1 bit adder/subtractor.
module muldiv_shift_core
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] load_low,
    input  logic [WIDTH-1:0] load_operand,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] low
);

    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    always_comb begin
        sum   = {1'b0, acc} + (low[0] ? {1'b0, operand} : '0);
        trial = {acc, low[WIDTH-1]};
        diff  = trial - {1'b0, operand};
    end

    // NOTE: pure datapath registers carry no reset; load always overwrites them
    // before a result can be consumed, and an aborted op is never read out.
    always_ff @(posedge clk) begin
        if (load) begin
            acc     <= '0;
            low     <= load_low;
            operand <= load_operand;
        end else if (step) begin
            if (mode == MODE_MUL) begin
                acc <= sum[WIDTH:1];
                low <= {sum[0], low[WIDTH-1:1]};
            end else if (!diff[WIDTH]) begin
                acc <= diff[WIDTH-1:0];
                low <= {low[WIDTH-2:0], 1'b1};
            end else begin
                acc <= trial[WIDTH-1:0];
                low <= {low[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MIPS multiply/divide sequencer owning HI/LO and raising muldivstall.
// Optional MULDIV_EARLY_OUT_EN: multiply leaves the loop once the remaining multiplier is zero.
module muldiv_sequencer
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hiread,
    input  logic             loread,
    input  logic             hiwrite,
    input  logic             lowrite,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             muldivstall
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t              state;
    logic [CW-1:0]       count;
    logic                sign_a, sign_b, is_div, div0;
    logic                op_signed, op_div, accept, early;
    logic [WIDTH-1:0]    abs_a, abs_b, acc, low;
    logic [2*WIDTH-1:0]  prod, prod_fix;
    logic [WIDTH-1:0]    res_hi, res_lo;
    mode_t               core_mode;

    assign op_signed   = !op[0];
    assign op_div      = op[1];
    assign accept      = (state == IDLE) && start;
    assign busy        = (state != IDLE);
    assign muldivstall = busy && (start || hiread || loread || hiwrite || lowrite);
    assign core_mode   = (state == DIV) ? MODE_DIV : MODE_MUL;

    // NOTE: every always_comb output gets a value on every path, so no latches.
    always_comb begin
        abs_a = (op_signed && srca[WIDTH-1]) ? -srca : srca;
        abs_b = (op_signed && srcb[WIDTH-1]) ? -srcb : srcb;
    end

    muldiv_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk          (clk),
        .load         (accept),
        .step         ((state == MUL) || (state == DIV)),
        .mode         (core_mode),
        .load_low     (op_div ? abs_a : abs_b),
        .load_operand (op_div ? abs_b : abs_a),
        .acc          (acc),
        .low          (low)
    );

`ifdef MULDIV_EARLY_OUT_EN
    // Shadow of the multiplier bits not yet consumed by the loop.
    logic [WIDTH-1:0] mrem;

    always_ff @(posedge clk) begin
        if (accept)
            mrem <= abs_b;
        else if (state == MUL)
            mrem <= mrem >> 1;
    end

    assign early = (state == MUL) && (mrem[WIDTH-1:1] == '0);
`else
    assign early = 1'b0;
`endif

    always_comb begin
        prod = {acc, low};
`ifdef MULDIV_EARLY_OUT_EN
        // Skipped iterations would only have shifted; apply them in one go.
        prod = prod >> (LAST - count);
`endif
        prod_fix = (sign_a ^ sign_b) ? -prod : prod;
        if (is_div) begin
            res_hi = sign_a ? -acc : acc;
            res_lo = div0 ? '1 : ((sign_a ^ sign_b) ? -low : low);
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            is_div <= 1'b0;
            div0   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= op_div ? DIV : MUL;
                        count  <= '0;
                        sign_a <= op_signed && srca[WIDTH-1];
                        sign_b <= op_signed && srcb[WIDTH-1];
                        is_div <= op_div;
                        div0   <= op_div && (srcb == '0);
                    end else begin
                        if (hiwrite) hi <= srca;
                        if (lowrite) lo <= srca;
                    end
                end
                MUL, DIV: begin
                    if (count == LAST || early)
                        state <= FIX;
                    else
                        count <= count + 1'b1;
                end
                FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    count <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
